// File: rtl/axis_frame_tx.sv
// AXI4-Stream video frame transmitter: emits a WIDTH x HEIGHT raster of
// test-pattern pixels {y[7:0], x[7:0], frame_cnt} with SOF on tuser[0]
// and end-of-line on tlast, inserting H_GAP idle cycles after each line.
// Optional macro AXIS_FRAME_TX_SOL_EN drives tuser[1] as start-of-line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame in progress, waiting for start
// ACTIVE    | presenting the beat at (x, y); advances on acceptance
// GAP       | inter-line idle cycles (tvalid low), H_GAP cycles long
// FRAME_END | one idle cycle after the last beat; frame_done, frame_cnt++
`timescale 1ns/1ps

module axis_frame_tx #(
   parameter int DATA_W = 24,
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int H_GAP  = 4
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              start,
   input  logic              continuous,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [7:0]        m_axis_tuser,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic              frame_done
);

   // Counters are at least 8 bits so the pattern can always take [7:0].
   localparam int XW    = ($clog2(WIDTH)  > 8) ? $clog2(WIDTH)  : 8;
   localparam int YW    = ($clog2(HEIGHT) > 8) ? $clog2(HEIGHT) : 8;
   localparam int GAP_W = (H_GAP > 1) ? $clog2(H_GAP) : 1;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ACTIVE    = 2'd1;
   localparam logic [1:0] S_GAP       = 2'd2;
   localparam logic [1:0] S_FRAME_END = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [7:0]       fcnt_q, fcnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             armed_q;
   logic             x_last, y_last;

   assign x_last = (x_q == XW'(WIDTH - 1));
   assign y_last = (y_q == YW'(HEIGHT - 1));

   // Next-state logic: raster walk, gap down-counter and frame sequencing.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      fcnt_d  = fcnt_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            // armed_q blocks a start seen on the first edge after reset release
            if (start && armed_q) begin
               state_d = S_ACTIVE;
               x_d     = '0;
               y_d     = '0;
            end
         end
         S_ACTIVE: begin
            if (m_axis_tready) begin
               if (x_last) begin
                  x_d = '0;
                  if (y_last) begin
                     y_d     = '0;
                     state_d = S_FRAME_END;
                  end else begin
                     y_d = y_q + 1'b1;
                     if (H_GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(H_GAP - 1);
                     end
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_ACTIVE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         S_FRAME_END: begin
            fcnt_d  = fcnt_q + 1'b1;
            y_d     = '0;
            state_d = continuous ? S_ACTIVE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         fcnt_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fcnt_q  <= fcnt_d;
         gap_q   <= gap_d;
      end
   end

   // Goes high one edge after reset release; gates start on that first edge.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
      end
   end

   // Outputs decode registered state only, so tvalid never depends on tready
   // and everything drops to zero as soon as reset asserts.
   assign m_axis_tvalid = (state_q == S_ACTIVE);
   assign m_axis_tdata  = m_axis_tvalid ? DATA_W'({y_q[7:0], x_q[7:0], fcnt_q})
                                        : '0;
   assign m_axis_tlast  = m_axis_tvalid && x_last;
   assign m_axis_tuser[0] = m_axis_tvalid && (x_q == '0) && (y_q == '0);
`ifdef AXIS_FRAME_TX_SOL_EN
   assign m_axis_tuser[1] = m_axis_tvalid && (x_q == '0);
`else
   assign m_axis_tuser[1] = 1'b0;
`endif
   assign m_axis_tuser[7:2] = '0;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_FRAME_END);

endmodule

// File: doc/axis_frame_tx.md
Name: axis_frame_tx

Overview:
- AXI4-Stream video frame transmitter. Generates a raster of WIDTH x HEIGHT pixel beats with a deterministic test pattern.
- Sideband: tuser[0] = start-of-frame on the first beat, tlast = end-of-line on the last beat of each row.
- Fully honours tready backpressure. Sits at the head of the image pipeline, feeding the processing chain and sideband delay stages downstream.

Parameters:
- DATA_W, 24, pixel width; must be 24 (pattern packing below).
- WIDTH, 640, active pixels per line; at least 2.
- HEIGHT, 480, lines per frame; at least 2.
- H_GAP, 4, idle cycles (tvalid=0) inserted after each accepted tlast beat; 0 means no gap.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a frame; ignored unless idle
- continuous  in  1  when high, a new frame starts automatically after the last beat of a frame
- m_axis_tdata  out  DATA_W  pixel data
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  8  bit0 = SOF; bit1 per optional feature; bits 7:2 always 0
- m_axis_tlast  out  1  end of line
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse on the cycle after the final beat of a frame is accepted

Behaviour:
- Reset (aresetn low, asynchronous) forces all outputs to 0:
  - tvalid, tdata, tuser, tlast, busy, frame_done.
  - x, y and frame_cnt (8-bit) counters cleared; state = IDLE.
  - Reset mid-frame abandons the frame; no partial-line completion.
- Handshake:
  - A beat is accepted when tvalid && tready on a rising edge.
  - While tvalid=1 and tready=0, tdata, tuser and tlast are held stable.
  - tvalid never deasserts without acceptance.
  - tvalid has no combinational dependence on tready.
- Pattern: tdata = {y[7:0], x[7:0], frame_cnt}. x and y are zero-based.
- Sideband:
  - tuser[0] = 1 only at x=0, y=0.
  - tlast = 1 only at x=WIDTH-1.
- States:
  - IDLE: tvalid=0. start=1 leads to ACTIVE next cycle, with x=y=0 and the first beat presented in the ACTIVE cycle.
  - ACTIVE: tvalid=1. On each acceptance, x increments.
    - On acceptance at x=WIDTH-1: x wraps to 0 and y increments.
    - If y was HEIGHT-1, go to FRAME_END; otherwise go to GAP if H_GAP>0, else stay ACTIVE.
  - GAP: tvalid=0 for exactly H_GAP cycles, then ACTIVE.
  - FRAME_END (1 cycle): tvalid=0, frame_done=1, frame_cnt increments (wraps 255 to 0), y clears.
    - Next state is ACTIVE if continuous=1 sampled this cycle, else IDLE.
    - No H_GAP is added after the last line.
- Back-to-back beats within a line: one beat per cycle when tready is held high.
- Boundary cases:
  - start while busy: ignored.
  - start and reset deassertion in the same cycle: start is ignored.
  - continuous dropping mid-frame: current frame completes, then IDLE.
  - tready low during the tlast beat: the line does not advance and GAP does not begin until acceptance.
- Throughput, per line with tready=1: WIDTH beats + H_GAP idle cycles. Per frame: +1 cycle for FRAME_END.

Optional Feature:
- Macro AXIS_FRAME_TX_SOL_EN.
- When defined: tuser[1] = 1 on the first beat of every line (x=0), including line 0.
- When undefined: tuser[1] is tied to 0, with no counter or comparator logic for it.
- All other behaviour is identical in both cases.

Test Plan:
- WIDTH=4, HEIGHT=3, H_GAP=2, tready=1, one start pulse:
  - 12 beats in three 4-beat bursts, each burst followed by 2 idle cycles.
  - tuser[0] only on beat 0 (tdata=0x000000); tlast on beats 3, 7, 11.
  - Last tdata = 0x020300.
  - frame_done pulses once; busy returns to 0 after it.
- Same config, tready toggling 1,0,0,1 repeatedly:
  - tdata, tuser and tlast stable through every stall.
  - Exactly 12 accepted beats with the same sequence as the tready=1 case.
- continuous=1 for 3 frames:
  - frame_cnt field reads 0x00, 0x01, 0x02.
  - Exactly 1 idle cycle (FRAME_END) between the last beat of a frame and the next SOF beat.
- Assert aresetn low for 1 cycle while on beat 6:
  - All outputs are 0 immediately (asynchronously).
  - After release, a new start produces SOF with tdata=0x000000.
- start pulsed while busy, at beat 5: ignored; total beats remain 12; no second frame.
- AXIS_FRAME_TX_SOL_EN defined, WIDTH=4, HEIGHT=3:
  - tuser = 0x03 on beat 0 and 0x02 on beats 4 and 8; 0x00 elsewhere.
  - When undefined, tuser[1] is never set.
